// File: rtl/ap_ptr_file_if.sv
// ap_ptr_file_if: pointer-file operation inputs and registered address/status outputs
interface ap_ptr_file_if #(parameter int WIDTH = 16);
  logic [2:0]       APSel;
  logic [1:0]       PtrOp;
  logic             OpValid;
  logic [WIDTH-1:0] LoadData;
  logic [WIDTH-1:0] Addr;
  logic             OpDone;
  logic             Wrap;
  logic             PtrErr;
  modport master (output APSel, PtrOp, OpValid, LoadData, input Addr, OpDone, Wrap, PtrErr);
  modport slave  (input APSel, PtrOp, OpValid, LoadData, output Addr, OpDone, Wrap, PtrErr);
endinterface

// File: rtl/ap_ptr_file.sv
// ap_ptr_file: eight pointers (P0 hard-wired zero) with load/inc/dec and registered write-through address.
// Define AP_PTR_ERR_EN to build the sticky PtrErr flag set on any wrap.
module ap_ptr_file #(parameter int WIDTH = 16) (
  input logic clk,
  input logic rst,
  ap_ptr_file_if.slave bus
);
  typedef logic [WIDTH-1:0] word_t;
  word_t ptr_q [8];
  word_t ptr_d [8];
  word_t addr_q, addr_d, cur, nxt;
  logic  done_q, done_d, wrap_q, wrap_d, wr;
  always_comb begin
    ptr_d  = ptr_q;
    cur    = ptr_q[bus.APSel];
    nxt    = bus.PtrOp == 2'b01 ? bus.LoadData :
             bus.PtrOp == 2'b10 ? cur + 1'b1 :
             bus.PtrOp == 2'b11 ? cur - 1'b1 : cur;
    wr     = bus.OpValid && bus.APSel != 3'd0;
    wrap_d = wr && ((bus.PtrOp == 2'b10 && &cur) || (bus.PtrOp == 2'b11 && cur == '0));
    if (wr) ptr_d[bus.APSel] = nxt;
    ptr_d[0] = '0;
    addr_d = ptr_d[bus.APSel];
    done_d = bus.OpValid;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '{default: '0};
      addr_q <= '0;
      done_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      addr_q <= addr_d;
      done_q <= done_d;
      wrap_q <= wrap_d;
    end
  end
`ifdef AP_PTR_ERR_EN
  logic err_q, err_d;
  always_comb err_d = err_q | wrap_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end
  assign bus.PtrErr = err_q;
`else
  assign bus.PtrErr = 1'b0;
`endif
  assign bus.Addr   = addr_q;
  assign bus.OpDone = done_q;
  assign bus.Wrap   = wrap_q;
endmodule

// File: tb/tb_ap_ptr_file.sv
// tb_ap_ptr_file: directed self-checking bench for ap_ptr_file
module tb_ap_ptr_file;
  localparam logic [1:0] HOLD = 2'b00, LOAD = 2'b01, INC = 2'b10, DEC = 2'b11;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic err_exp = 1'b0;
  logic err_en;
  ap_ptr_file_if #(.WIDTH(16)) bus ();
  ap_ptr_file #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [2:0] sel, input logic [1:0] op, input logic vld, input logic [15:0] data);
    bus.APSel = sel; bus.PtrOp = op; bus.OpValid = vld; bus.LoadData = data;
    @(posedge clk);
    #1;
  endtask
  task automatic status(input string tag, input logic [15:0] a, input logic d, input logic w);
    chk({tag, "_addr"}, bus.Addr, a);
    chk({tag, "_done"}, {15'd0, bus.OpDone}, {15'd0, d});
    chk({tag, "_wrap"}, {15'd0, bus.Wrap}, {15'd0, w});
    if (w && err_en) err_exp = 1'b1;
    chk({tag, "_err"}, {15'd0, bus.PtrErr}, {15'd0, err_exp});
  endtask
  initial begin
`ifdef AP_PTR_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    bus.APSel = 3'd0; bus.PtrOp = HOLD; bus.OpValid = 1'b0; bus.LoadData = 16'h0;
    #2;
    status("por", 16'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int n = 1; n < 8; n++) begin
      step(3'(n), LOAD, 1'b1, 16'(16'h1111 * n));
      status($sformatf("load%0d", n), 16'(16'h1111 * n), 1'b1, 1'b0);
    end
    for (int n = 1; n < 8; n++) begin
      step(3'(n), INC, 1'b0, 16'hDEAD);
      status($sformatf("rd%0d", n), 16'(16'h1111 * n), 1'b0, 1'b0);
    end
    step(3'd0, LOAD, 1'b1, 16'hBEEF);
    status("p0_load", 16'h0, 1'b1, 1'b0);
    step(3'd0, HOLD, 1'b0, 16'h0);
    status("p0_idle", 16'h0, 1'b0, 1'b0);
    step(3'd0, DEC, 1'b1, 16'h0);
    status("p0_dec", 16'h0, 1'b1, 1'b0);
    step(3'd5, LOAD, 1'b1, 16'hFFFF);
    status("p5_ld", 16'hFFFF, 1'b1, 1'b0);
    step(3'd5, INC, 1'b1, 16'h0);
    status("p5_inc", 16'h0000, 1'b1, 1'b1);
    step(3'd5, HOLD, 1'b0, 16'h0);
    status("p5_idle", 16'h0000, 1'b0, 1'b0);
    step(3'd5, DEC, 1'b1, 16'h0);
    status("p5_dec", 16'hFFFF, 1'b1, 1'b1);
    step(3'd5, DEC, 1'b1, 16'h0);
    status("p5_dec2", 16'hFFFE, 1'b1, 1'b0);
    step(3'd2, LOAD, 1'b1, 16'h0010);
    status("p2_ld", 16'h0010, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step(3'd2, INC, 1'b1, 16'h0);
      status($sformatf("b2b%0d", k), 16'(16'h0010 + k), 1'b1, 1'b0);
    end
    step(3'd2, INC, 1'b0, 16'h0);
    status("b2b_end", 16'h0014, 1'b0, 1'b0);
    step(3'd4, HOLD, 1'b1, 16'h9999);
    status("p4_hold", 16'h4444, 1'b1, 1'b0);
    step(3'd3, LOAD, 1'b1, 16'h1234);
    status("p3_ld", 16'h1234, 1'b1, 1'b0);
    bus.APSel = 3'd3; bus.PtrOp = LOAD; bus.OpValid = 1'b1; bus.LoadData = 16'h5555;
    rst = 1'b0;
    err_exp = 1'b0;
    #1;
    status("rst_async", 16'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    status("rst_hold", 16'h0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    step(3'd3, HOLD, 1'b0, 16'h0);
    status("rst_p3", 16'h0, 1'b0, 1'b0);
    step(3'd7, HOLD, 1'b0, 16'h0);
    status("rst_p7", 16'h0, 1'b0, 1'b0);
    step(3'd3, LOAD, 1'b1, 16'h00AB);
    status("post_rst_ld", 16'h00AB, 1'b1, 1'b0);
    step(3'd3, DEC, 1'b1, 16'h0);
    status("post_rst_dec", 16'h00AA, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
